// File: rtl/piano_pkg.sv
// Shared defaults, ceiling-log2 helper and voice state type for the piano voice allocator.
package piano_pkg;

    localparam int unsigned NUM_KEYS_DEF   = 8;
    localparam int unsigned NUM_VOICES_DEF = 3;
    localparam int unsigned DB_CYCLES_DEF  = 1000;

    typedef enum logic {
        VOICE_IDLE   = 1'b0,
        VOICE_ACTIVE = 1'b1
    } voice_state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One piano switch: 2-flop synchroniser, stability counter and debounced level register.
module key_debounce import piano_pkg::*; #(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    output logic o_key
);

    localparam int unsigned CNT_W = (clog2(DB_CYCLES) > 1) ? clog2(DB_CYCLES) : 1;

    logic             r_s1;
    logic             r_s2;
    logic             r_key;
    logic [CNT_W-1:0] r_cnt;

    // Level flips only after DB_CYCLES consecutive synchronised samples disagree with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_key <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            if (r_s2 == r_key) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_key <= ~r_key;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_key = r_key;

endmodule

// File: rtl/key_voice_alloc.sv
// Debounces piano switches and assigns pressed keys to a small pool of LFSR voices.
module key_voice_alloc import piano_pkg::*; #(
    parameter  int unsigned NUM_KEYS   = NUM_KEYS_DEF,
    parameter  int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter  int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    localparam int unsigned KEY_W      = (clog2(NUM_KEYS) > 1) ? clog2(NUM_KEYS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         sw,
    output logic [NUM_KEYS-1:0]         key_state,
    output logic [NUM_VOICES-1:0]       voice_en,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic                        overflow
);

    logic [NUM_KEYS-1:0] w_key;
    logic [NUM_KEYS-1:0] r_key_d;
    logic [NUM_KEYS-1:0] r_pend;
    logic [NUM_KEYS-1:0] w_pend_nxt;
    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_fall;
    voice_state_t        r_vstate     [NUM_VOICES];
    voice_state_t        w_vstate_nxt [NUM_VOICES];
    logic [KEY_W-1:0]    r_vkey       [NUM_VOICES];
    logic [KEY_W-1:0]    w_vkey_nxt   [NUM_VOICES];
    logic                r_ovf;
    logic                w_ovf_nxt;
    logic                w_srv_vld;
    logic [KEY_W-1:0]    w_srv_key;
    logic                w_srv_held;
    logic                w_free_vld;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .i_sw  (sw[k]),
            .o_key (w_key[k])
        );
    end

    assign w_rise = w_key & ~r_key_d;
    assign w_fall = ~w_key & r_key_d;

    // Release voices of falling keys; serve the lowest pending key into the lowest voice idle at cycle start
    always_comb begin
        w_pend_nxt = (r_pend | w_rise) & ~w_fall;
        w_ovf_nxt  = 1'b0;
        w_srv_vld  = 1'b0;
        w_srv_key  = '0;
        w_srv_held = 1'b0;
        w_free_vld = 1'b0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            w_vstate_nxt[v] = r_vstate[v];
            w_vkey_nxt[v]   = r_vkey[v];
            if (r_vstate[v] == VOICE_ACTIVE && w_fall[r_vkey[v]]) w_vstate_nxt[v] = VOICE_IDLE;
        end
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (!w_srv_vld && r_pend[k] && !w_fall[k]) begin
                w_srv_vld = 1'b1;
                w_srv_key = KEY_W'(k);
            end
        end
        if (w_srv_vld) w_pend_nxt[w_srv_key] = 1'b0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (r_vstate[v] == VOICE_ACTIVE && r_vkey[v] == w_srv_key) w_srv_held = 1'b1;
        end
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (w_srv_vld && !w_srv_held && !w_free_vld && r_vstate[v] == VOICE_IDLE) begin
                w_free_vld      = 1'b1;
                w_vstate_nxt[v] = VOICE_ACTIVE;
                w_vkey_nxt[v]   = w_srv_key;
            end
        end
        if (w_srv_vld && !w_srv_held && !w_free_vld) w_ovf_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_d <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                r_vstate[v] <= VOICE_IDLE;
                r_vkey[v]   <= '0;
            end
        end else begin
            r_key_d <= w_key;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                r_vstate[v] <= w_vstate_nxt[v];
                r_vkey[v]   <= w_vkey_nxt[v];
            end
        end
    end

    assign key_state = w_key;
    assign overflow  = r_ovf;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign voice_en[v]                  = (r_vstate[v] == VOICE_ACTIVE);
        assign voice_key[v*KEY_W +: KEY_W]  = r_vkey[v];
    end

endmodule
